// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit and its ALU decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_e;

    localparam int unsigned ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_ORR = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_MOV = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing command field Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of the data-processing command into ALU select, flag
// write enables (ungated), no-write indication and illegal-encoding detection.
module alu_decoder
    import mc_pkg::*;
#(
    parameter bit EN_MOV = 1'b1
) (
    input  logic [4:0]          Funct,
    input  logic [1:0]          Op,
    output logic [ALU_OP_W-1:0] ALUControl,
    output logic [1:0]          FlagW,
    output logic                NoWrite,
    output logic                IllegalDP
);

    logic arith;
    logic cmp_tst;
    logic legal;
    logic s_bit;

    always_comb begin
        ALUControl = ALU_ADD;
        arith      = 1'b0;
        cmp_tst    = 1'b0;
        legal      = 1'b1;
        case (Funct[4:1])
            CMD_ADD: begin ALUControl = ALU_ADD; arith = 1'b1; end
            CMD_SUB: begin ALUControl = ALU_SUB; arith = 1'b1; end
            CMD_AND: ALUControl = ALU_AND;
            CMD_ORR: ALUControl = ALU_ORR;
            CMD_CMP: begin ALUControl = ALU_SUB; arith = 1'b1; cmp_tst = 1'b1; end
            CMD_TST: begin ALUControl = ALU_AND; cmp_tst = 1'b1; end
            CMD_MOV: begin
                if (EN_MOV) ALUControl = ALU_MOV;
                else        legal      = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        // Compares and tests always update flags regardless of the S bit
        s_bit     = Funct[0] | cmp_tst;
        FlagW     = {s_bit, s_bit & arith};
        NoWrite   = cmp_tst;
        IllegalDP = (Op == OP_DP) && !legal;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit sequencing fetch/decode/execute/memory/writeback over
// a shared memory port and ALU; write enables are gated by CondEx and reset.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned ALUCTRL_W       = 3,
    parameter bit          EN_MOV          = 1'b1,
    parameter bit          NOWRITE_CMP_TST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 CondEx,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 RegW,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           FlagW,
    output logic                 Illegal
);

    state_e state_q, state_d;

    logic [ALU_OP_W-1:0] dec_alu;
    logic [1:0]          dec_flagw;
    logic                dec_nowrite;
    logic                dec_illegal;
    logic                rd_pc;

    alu_decoder #(.EN_MOV(EN_MOV)) u_alu_decoder (
        .Funct      (Funct[4:0]),
        .Op         (Op),
        .ALUControl (dec_alu),
        .FlagW      (dec_flagw),
        .NoWrite    (dec_nowrite),
        .IllegalDP  (dec_illegal)
    );

    assign rd_pc = (Rd == 4'hF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemW       = 1'b0;
        IRWrite    = 1'b0;
        RegW       = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_WDATA;
        ALUControl = ALUCTRL_W'(ALU_ADD);
        FlagW      = 2'b00;
        Illegal    = 1'b0;
        ImmSrc     = Op;
        RegSrc     = {Op == OP_MEM, Op == OP_BR};

        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // PC+8 computed here for use as R15 by the next state
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_MEM: state_d = S_MEMADR;
                    OP_BR:  state_d = S_BRANCH;
                    OP_DP: begin
                        if (dec_illegal) begin
                            Illegal = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = Funct[5] ? S_EXECI : S_EXECR;
                        end
                    end
                    default: begin
                        Illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                MemW    = CondEx;
                state_d = S_FETCH;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = CondEx;
                PCWrite   = CondEx & rd_pc;
                state_d   = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_WDATA;
                ALUControl = ALUCTRL_W'(dec_alu);
                FlagW      = dec_flagw & {2{CondEx}};
                state_d    = (NOWRITE_CMP_TST && dec_nowrite) ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegW      = CondEx;
                PCWrite   = CondEx & rd_pc;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = CondEx;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Abandon any in-flight instruction without side effects
        if (reset) begin
            PCWrite = 1'b0;
            IRWrite = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            FlagW   = 2'b00;
            Illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed test of multicycle_controller: per-cycle output signatures for each
// instruction class, condition gating, illegal decode and async reset.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
    logic       PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, Illegal;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW;
    logic [2:0] ALUControl;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .CondEx     (CondEx),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemW       (MemW),
        .IRWrite    (IRWrite),
        .RegW       (RegW),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUControl, FlagW, Illegal};

    function automatic logic [15:0] sig(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic rw, input logic [1:0] rs,
                                        input logic a, input logic [1:0] b,
                                        input logic [2:0] alu, input logic [1:0] fw,
                                        input logic il);
        return {pcw, adr, mw, irw, rw, rs, a, b, alu, fw, il};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                          input logic c);
        Op = op; Funct = f; Rd = rd; CondEx = c;
        #0;
    endtask

    logic [15:0] SIG_RST, SIG_F, SIG_D, SIG_DILL, SIG_MEMADR, SIG_MEMRD;

    initial begin
        SIG_RST    = sig(0,0,0,0,0,2'b10,1,2'b10,3'b000,2'b00,0);
        SIG_F      = sig(1,0,0,1,0,2'b10,1,2'b10,3'b000,2'b00,0);
        SIG_D      = sig(0,0,0,0,0,2'b10,1,2'b10,3'b000,2'b00,0);
        SIG_DILL   = sig(0,0,0,0,0,2'b10,1,2'b10,3'b000,2'b00,1);
        SIG_MEMADR = sig(0,0,0,0,0,2'b00,0,2'b01,3'b000,2'b00,0);
        SIG_MEMRD  = sig(0,1,0,0,0,2'b00,0,2'b00,3'b000,2'b00,0);

        reset = 1'b1;
        set_in(2'b00, 6'b000000, 4'h0, 1'b0);
        #2;
        chk("reset_outputs", obs, SIG_RST);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // ADD R1,R2,#5
        set_in(2'b00, 6'b101000, 4'h1, 1'b1);
        chk("add_fetch", obs, SIG_F);
        chk("add_immsrc", 16'(ImmSrc), 16'h0);
        tick(); chk("add_decode", obs, SIG_D);
        tick(); chk("add_execi", obs, sig(0,0,0,0,0,2'b00,0,2'b01,3'b000,2'b00,0));
        tick(); chk("add_aluwb", obs, sig(0,0,0,0,1,2'b00,0,2'b00,3'b000,2'b00,0));
        tick(); chk("add_refetch", obs, SIG_F);

        // LDR to R15
        set_in(2'b01, 6'b011001, 4'hF, 1'b1);
        chk("ldr_regsrc", 16'(RegSrc), 16'h2);
        chk("ldr_immsrc", 16'(ImmSrc), 16'h1);
        tick(); chk("ldr_decode", obs, SIG_D);
        tick(); chk("ldr_memadr", obs, SIG_MEMADR);
        tick(); chk("ldr_memrd", obs, SIG_MEMRD);
        tick(); chk("ldr_memwb", obs, sig(1,0,0,0,1,2'b01,0,2'b00,3'b000,2'b00,0));
        tick(); chk("ldr_refetch", obs, SIG_F);

        // STR with failed condition
        set_in(2'b01, 6'b011000, 4'h3, 1'b0);
        tick(); chk("str_decode", obs, SIG_D);
        tick(); chk("str_memadr", obs, SIG_MEMADR);
        tick(); chk("str_memwr_nc", obs, SIG_MEMRD);
        tick(); chk("str_refetch", obs, SIG_F);

        // CMP R0,#3 skips writeback
        set_in(2'b00, 6'b110101, 4'h0, 1'b1);
        tick(); chk("cmp_decode", obs, SIG_D);
        tick(); chk("cmp_execi", obs, sig(0,0,0,0,0,2'b00,0,2'b01,3'b001,2'b11,0));
        tick(); chk("cmp_refetch", obs, SIG_F);

        // TST
        set_in(2'b00, 6'b110001, 4'h0, 1'b1);
        tick(); chk("tst_decode", obs, SIG_D);
        tick(); chk("tst_execi", obs, sig(0,0,0,0,0,2'b00,0,2'b01,3'b010,2'b10,0));
        tick(); chk("tst_refetch", obs, SIG_F);

        // SUBS PC,Rn,Rm register form
        set_in(2'b00, 6'b000101, 4'hF, 1'b1);
        tick(); chk("sub_decode", obs, SIG_D);
        tick(); chk("sub_execr", obs, sig(0,0,0,0,0,2'b00,0,2'b00,3'b001,2'b11,0));
        tick(); chk("sub_aluwb_pc", obs, sig(1,0,0,0,1,2'b00,0,2'b00,3'b000,2'b00,0));
        tick(); chk("sub_refetch", obs, SIG_F);

        // ORRS with failed condition: flags and write suppressed
        set_in(2'b00, 6'b011001, 4'h2, 1'b0);
        tick(); chk("orr_decode", obs, SIG_D);
        tick(); chk("orr_execr_nc", obs, sig(0,0,0,0,0,2'b00,0,2'b00,3'b011,2'b00,0));
        tick(); chk("orr_aluwb_nc", obs, sig(0,0,0,0,0,2'b00,0,2'b00,3'b000,2'b00,0));
        tick(); chk("orr_refetch", obs, SIG_F);

        // MOV immediate
        set_in(2'b00, 6'b111010, 4'h4, 1'b1);
        tick(); chk("mov_decode", obs, SIG_D);
        tick(); chk("mov_execi", obs, sig(0,0,0,0,0,2'b00,0,2'b01,3'b100,2'b00,0));
        tick(); chk("mov_aluwb", obs, sig(0,0,0,0,1,2'b00,0,2'b00,3'b000,2'b00,0));
        tick(); chk("mov_refetch", obs, SIG_F);

        // B taken
        set_in(2'b10, 6'b000000, 4'h0, 1'b1);
        chk("b_regsrc", 16'(RegSrc), 16'h1);
        tick(); chk("b_decode", obs, SIG_D);
        tick(); chk("b_branch_taken", obs, sig(1,0,0,0,0,2'b10,0,2'b01,3'b000,2'b00,0));
        tick(); chk("b_refetch", obs, SIG_F);

        // B not taken
        set_in(2'b10, 6'b000000, 4'h0, 1'b0);
        tick(); chk("bnt_decode", obs, SIG_D);
        tick(); chk("bnt_branch", obs, sig(0,0,0,0,0,2'b10,0,2'b01,3'b000,2'b00,0));
        tick(); chk("bnt_refetch", obs, SIG_F);

        // Op=11 illegal
        set_in(2'b11, 6'b000000, 4'h0, 1'b1);
        tick(); chk("op11_decode_ill", obs, SIG_DILL);
        tick(); chk("op11_refetch", obs, SIG_F);

        // Unsupported DP command 0001
        set_in(2'b00, 6'b000010, 4'h0, 1'b1);
        tick(); chk("dpill_decode", obs, SIG_DILL);
        tick(); chk("dpill_refetch", obs, SIG_F);

        // Async reset in the middle of a store
        set_in(2'b01, 6'b011000, 4'h1, 1'b1);
        tick(); chk("rst_str_decode", obs, SIG_D);
        tick(); chk("rst_str_memadr", obs, SIG_MEMADR);
        tick(); chk("rst_str_memwr", obs, sig(0,1,1,0,0,2'b00,0,2'b00,3'b000,2'b00,0));
        #2 reset = 1'b1;
        #1 chk("rst_mid_memwr", obs, SIG_RST);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_release_fetch", obs, SIG_F);
        tick(); chk("rst_release_decode", obs, SIG_D);
        tick(); chk("rst_release_memadr", obs, SIG_MEMADR);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Next-generation control unit for the ARM-subset processor. It replaces the single-cycle decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over a shared memory port and a shared ALU.
- Keeps the same main/ALU decode semantics (DP, MOV, CMP, TST, LDR, STR, B) and adds per-state write-enable sequencing, condition gating and illegal-opcode detection.
- Sits between the instruction register and condition-flag logic on one side and the multicycle datapath on the other.

Parameters:
- ALUCTRL_W, 3: width of ALUControl; must be >=3.
- EN_MOV, 1: 1 = MOV decoded (ALUControl 3'b100, pass-B); 0 = MOV treated as illegal.
- NOWRITE_CMP_TST, 1: 1 = CMP and TST suppress the register write (ALUWB skipped, goes to FETCH).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- CondEx  in  1  condition-check result for the current instruction
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0=PC, 1=ALUOut as memory address
- MemW  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- RegW  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RnData, 1=PC
- ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- ALUControl  out  ALUCTRL_W  ALU operation select
- FlagW  out  2  [1]=NZ write, [0]=CV write
- Illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- State is in a single flop vector; all outputs are combinational from state plus the decode inputs (Moore, except the CondEx gating).
- Reset: state goes asynchronously to FETCH. While reset is high, PCWrite, IRWrite, RegW, MemW, FlagW and Illegal are forced to 0; the other outputs hold FETCH values. Reset mid-instruction abandons it, with no partial write.
- Transitions:
  - FETCH -> DECODE
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 or illegal DP -> FETCH with Illegal=1
  - MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR
  - MEMRD -> MEMWB -> FETCH
  - MEMWR -> FETCH
  - EXECR/EXECI -> ALUWB -> FETCH, except CMP/TST go directly -> FETCH when NOWRITE_CMP_TST=1
  - BRANCH -> FETCH
- Latency (cycles, counting FETCH): B 3, STR 4, DP 4 (CMP/TST 3), LDR 5.
- Per-state outputs (unlisted outputs = 0 or 00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (computes PC+8).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
  - MEMRD and MEMWR: AdrSrc=1. MEMWR additionally MemW=CondEx.
  - MEMWB: ResultSrc=01, RegW=CondEx; PCWrite=CondEx & (Rd==15).
  - EXECR: ALUSrcA=0, ALUSrcB=00. EXECI: ALUSrcA=0, ALUSrcB=01. Both: ALU decode active, FlagW gated by CondEx.
  - ALUWB: ResultSrc=00, RegW=CondEx; PCWrite=CondEx & (Rd==15).
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx.
- ALU decode on Funct[4:1]: 0100 ADD=000, 0010 SUB=001, 0000 AND=010, 1100 ORR=011, 1010 CMP=001, 1000 TST=010, 1101 MOV=100 (EN_MOV). Any other code is illegal.
- Flags: FlagW[1]=Funct[0], FlagW[0]=Funct[0] & (ADD|SUB|CMP). CMP and TST force S=1, so FlagW[1]=1 for both.
- Outside EXEC states: ALUControl=ADD, FlagW=00.
- ImmSrc and RegSrc are driven in every state, derived from Op.
- ALUControl is zero-extended to ALUCTRL_W.

Decomposition:
- Package mc_pkg: state enum typedef, ALU opcode localparams (ADD, SUB, AND, ORR, MOV), ResultSrc/ALUSrcB encodings, DP Funct[4:1] codes.
- Sub-module alu_decoder: combinational. Inputs Funct, Op; outputs ALUControl, FlagW (ungated), NoWrite, IllegalDP.
- The FSM and CondEx gating stay in the top.

Test Plan:
- ADD R1,R2,#5 (Op=00, Funct=101000), CondEx=1 -> states F,D,EXECI,ALUWB. ALUControl=000 in EXECI, RegW=1 in ALUWB only, FlagW=00. Total 4 cycles.
- LDR (Op=01, Funct=011001) -> F,D,MEMADR,MEMRD,MEMWB. AdrSrc=1 in MEMRD, ResultSrc=01 and RegW=1 in MEMWB. With Rd=15, PCWrite=1 in MEMWB.
- STR with CondEx=0 -> MEMWR reached but MemW=0. Next state FETCH.
- CMP R0,#3 (Funct=110101) with NOWRITE_CMP_TST=1 -> EXECI gives ALUControl=001, FlagW=11, then FETCH, never ALUWB. TST (Funct=110001) -> ALUControl=010, FlagW=10.
- B with CondEx=1 -> F,D,BRANCH with PCWrite=1 in BRANCH. With CondEx=0, PCWrite=0 in BRANCH. Op=11 -> Illegal=1 for exactly the DECODE cycle, then FETCH.
- Assert reset asynchronously mid-MEMWR -> state=FETCH immediately and MemW=0 the same cycle. After release, the first edge goes to DECODE with IRWrite=1 in the preceding cycle.
